muladd_initiator: RTL and testbench

MULADD_INITIATOR -- requirements
Module: muladd_initiator

---
 rtl/muladd_initiator.sv | 148 ++++++++++++++
 tb/tb_muladd_initiator.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muladd_initiator.sv
// Sequences one multiply-add job per host request: latches operands, pulses the core, collects the result.
// Optional watchdog on the core wait, enabled by defining MULADD_INITIATOR_WATCHDOG_EN.
module muladd_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [31:0] req_c,
    output logic        start,
    output logic [31:0] a_in,
    output logic [31:0] b_in,
    output logic [31:0] c_in,
    input  logic        finish,
    input  logic [31:0] y_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_y,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [15:0] jobs_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("muladd_initiator: TIMEOUT_CYCLES must be within 1..255");
    end

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] c_q, c_d;
    logic [31:0] y_q, y_d;
    logic [15:0] jobs_q, jobs_d;

`ifdef MULADD_INITIATOR_WATCHDOG_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wd_q, wd_d;
    logic       timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        y_d     = y_q;
        jobs_d  = jobs_q;
`ifdef MULADD_INITIATOR_WATCHDOG_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    c_d     = req_c;
                    state_d = START;
                end
            end
            START: begin
`ifdef MULADD_INITIATOR_WATCHDOG_EN
                wd_d = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                // A completion arriving on the last watchdog cycle still counts as a real result
                if (finish) begin
                    y_d     = y_out;
                    state_d = RESP;
`ifdef MULADD_INITIATOR_WATCHDOG_EN
                    timeout_d = 1'b0;
                end else if (wd_q == WD_LAST) begin
                    y_d       = '0;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    wd_d = wd_q + 8'd1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    jobs_d  = jobs_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            y_q     <= '0;
            jobs_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            y_q     <= y_d;
            jobs_q  <= jobs_d;
        end
    end

`ifdef MULADD_INITIATOR_WATCHDOG_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign rsp_timeout = timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign req_ready = (state_q == IDLE);
    assign start     = (state_q == START);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign a_in      = a_q;
    assign b_in      = b_q;
    assign c_in      = c_q;
    assign rsp_y     = y_q;
    assign jobs_done = jobs_q;

endmodule

// File: tb/tb_muladd_initiator.sv
// Randomized job-level bench for muladd_initiator; the core is modelled as y = a*b + c.
// Define MULADD_INITIATOR_WATCHDOG_EN to also exercise the watchdog abort path.
module tb_muladd_initiator;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a, req_b, req_c;
    logic        start;
    logic [31:0] a_in, b_in, c_in;
    logic        finish;
    logic [31:0] y_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_y;
    logic        rsp_timeout;
    logic        busy;
    logic [15:0] jobs_done;

    int testsRun    = 0;
    int testsFailed = 0;
    int expJobs     = 0;
    logic [31:0] lastY = '0;

    always #5 clock = ~clock;

    muladd_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_c(req_c),
        .start(start),
        .a_in(a_in),
        .b_in(b_in),
        .c_in(c_in),
        .finish(finish),
        .y_out(y_out),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_y(rsp_y),
        .rsp_timeout(rsp_timeout),
        .busy(busy),
        .jobs_done(jobs_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One complete job: optional idle gap with stray finish pulses, request, core completion
    // after finDelay extra wait cycles, then rsp_ready withheld for rdyDelay cycles.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                 input int idleGap, input int finDelay, input int rdyDelay);
        logic [31:0] expY;
        expY = a * b + c;
        rsp_ready = 1'b0;
        for (int i = 0; i < idleGap; i++) begin
            req_valid = 1'b0;
            finish    = 1'($urandom_range(0, 1));
            y_out     = $urandom;
            tick();
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_rsp_valid", rsp_valid, 0);
            checkOutput("idle_rsp_y", rsp_y, lastY);
        end
        checkOutput("accept_ready", req_ready, 1);
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_c = c;
        finish = 1'b0;
        tick();
        checkOutput("start_pulse", start, 1);
        checkOutput("start_busy", busy, 1);
        checkOutput("start_req_ready", req_ready, 0);
        checkOutput("a_in", a_in, a);
        checkOutput("b_in", b_in, b);
        checkOutput("c_in", c_in, c);
        req_valid = 1'($urandom_range(0, 1));
        req_a  = $urandom;
        req_b  = $urandom;
        req_c  = $urandom;
        finish = 1'($urandom_range(0, 1));
        y_out  = $urandom;
        tick();
        checkOutput("start_single", start, 0);
        checkOutput("wait_rsp_valid", rsp_valid, 0);
        finish = 1'b0;
        for (int i = 0; i < finDelay; i++) begin
            tick();
            checkOutput("wait_hold_rsp_valid", rsp_valid, 0);
            checkOutput("wait_hold_busy", busy, 1);
        end
        finish = 1'b1;
        y_out  = expY;
        tick();
        finish = 1'b0;
        y_out  = $urandom;
        checkOutput("rsp_valid", rsp_valid, 1);
        checkOutput("rsp_y", rsp_y, expY);
        checkOutput("rsp_timeout", rsp_timeout, 0);
        checkOutput("rsp_jobs_before", jobs_done, 32'(expJobs));
        for (int i = 0; i < rdyDelay; i++) begin
            req_valid = 1'b1;
            req_a  = $urandom;
            finish = 1'($urandom_range(0, 1));
            y_out  = $urandom;
            tick();
            checkOutput("resp_hold_valid", rsp_valid, 1);
            checkOutput("resp_hold_y", rsp_y, expY);
            checkOutput("resp_hold_req_ready", req_ready, 0);
            checkOutput("resp_hold_jobs", jobs_done, 32'(expJobs));
        end
        req_valid = 1'b0;
        finish    = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        expJobs = (expJobs + 1) & 16'hFFFF;
        lastY = expY;
        checkOutput("done_rsp_valid", rsp_valid, 0);
        checkOutput("done_jobs", jobs_done, 32'(expJobs));
        checkOutput("done_req_ready", req_ready, 1);
        checkOutput("done_a_hold", a_in, a);
    endtask

`ifdef MULADD_INITIATOR_WATCHDOG_EN
    task automatic applyTimeout(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_c = c;
        finish = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("wd_still_waiting", rsp_valid, 0);
        end
        tick();
        checkOutput("wd_rsp_valid", rsp_valid, 1);
        checkOutput("wd_rsp_timeout", rsp_timeout, 1);
        checkOutput("wd_rsp_y", rsp_y, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        expJobs = (expJobs + 1) & 16'hFFFF;
        lastY = '0;
        checkOutput("wd_jobs", jobs_done, 32'(expJobs));
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] bench did not finish");
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        finish    = 1'b0;
        y_out     = '0;
        rsp_ready = 1'b0;
        #12;
        checkOutput("reset_start", start, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_timeout", rsp_timeout, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_a_in", a_in, 0);
        checkOutput("reset_rsp_y", rsp_y, 0);
        checkOutput("reset_jobs", jobs_done, 0);
        reset_n = 1'b1;
        tick();
        checkOutput("released_req_ready", req_ready, 1);

        applyStimulus(32'd3, 32'd4, 32'd5, 0, 0, 0);
        checkOutput("first_result", rsp_y, 17);
        applyStimulus($urandom, $urandom, $urandom, 2, 1, 5);

        finish = 1'b1;
        y_out  = 32'hDEAD;
        tick();
        finish = 1'b0;
        checkOutput("idle_finish_busy", busy, 0);
        checkOutput("idle_finish_rsp_valid", rsp_valid, 0);
        checkOutput("idle_finish_rsp_y", rsp_y, lastY);

        for (int j = 0; j < 40; j++) begin
`ifdef MULADD_INITIATOR_WATCHDOG_EN
            applyStimulus($urandom, $urandom, $urandom, $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3));
`else
            applyStimulus($urandom, $urandom, $urandom, $urandom_range(0, 3),
                          $urandom_range(0, 6), $urandom_range(0, 3));
`endif
        end

`ifdef MULADD_INITIATOR_WATCHDOG_EN
        applyTimeout($urandom, $urandom, $urandom);
        applyStimulus($urandom, $urandom, $urandom, 0, 3, 0);
        applyTimeout($urandom, $urandom, $urandom);
        applyStimulus($urandom, $urandom, $urandom, 1, 0, 1);
`else
        applyStimulus($urandom, $urandom, $urandom, 0, 20, 0);
`endif

        req_valid = 1'b1;
        req_a = 32'h1111;
        req_b = 32'h2222;
        req_c = 32'h3333;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_start", start, 0);
        checkOutput("midreset_rsp_valid", rsp_valid, 0);
        checkOutput("midreset_jobs", jobs_done, 0);
        checkOutput("midreset_a_in", a_in, 0);
        expJobs = 0;
        lastY = '0;
        #2;
        reset_n = 1'b1;
        finish = 1'b1;
        y_out = 32'hBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post_reset_rsp_valid", rsp_valid, 0);
            checkOutput("post_reset_busy", busy, 0);
            checkOutput("post_reset_rsp_y", rsp_y, 0);
        end
        finish = 1'b0;
        applyStimulus($urandom, $urandom, $urandom, 1, 0, 0);
        checkOutput("post_reset_jobs", jobs_done, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
